// File: rtl/gcode_tx_fifo.sv
// gcode_tx_fifo: line-aware byte FIFO between a valid/ready G-code byte source
// and a UART transmitter using a tx_start/tx_busy handshake. Bytes are only
// released once a complete line (ending in 0x0A) is stored. If the FIFO fills
// with no complete line, the sticky overflow flag also releases bytes.
// Optional build macro TX_FIFO_STRIP_COMMENT_EN: when defined, bytes from ';'
// up to (but not including) the next 0x0A are handshaken but not stored.
module gcode_tx_fifo #(
  parameter int DEPTH  = 64,
  parameter int ADDR_W = 6
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  input  logic [7:0]        in_data,
  output logic              in_ready,
  input  logic              tx_busy,
  output logic              tx_start,
  output logic [7:0]        tx_data,
  output logic [ADDR_W:0]   level,
  output logic [ADDR_W:0]   line_count,
  output logic              overflow
);

  localparam logic [7:0]        NL       = 8'h0A;
  localparam logic [7:0]        SEMI     = 8'h3B;
  localparam logic [ADDR_W:0]   FULL_LVL = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0]   ONE_LVL  = (ADDR_W+1)'(1);
  localparam logic [ADDR_W-1:0] ONE_PTR  = ADDR_W'(1);

  typedef enum logic [1:0] {IDLE, START, WAIT_HI, WAIT_LO} state_t;

  state_t            state;
  logic [1:0]        hi_cnt;
  logic [ADDR_W-1:0] wr_ptr;
  logic [ADDR_W-1:0] rd_ptr;
  logic [7:0]        mem [DEPTH];

  logic              push;
  logic              store;
  logic              pop;
  logic              nl_in;
  logic              nl_out;
  logic              rel;
  logic [7:0]        head;
  logic [ADDR_W:0]   level_next;
  logic [ADDR_W:0]   lc_next;

  assign in_ready = (level != FULL_LVL);
  assign push     = in_valid && in_ready;
  assign head     = mem[rd_ptr];
  assign rel      = (line_count != '0) || overflow;
  // A pop only starts from IDLE, and never while the UART still reports busy.
  assign pop      = (state == IDLE) && (level != '0) && rel && !tx_busy;
  assign nl_out   = pop && (head == NL);

`ifdef TX_FIFO_STRIP_COMMENT_EN
  logic strip_flag;

  // The newline is always stored. Everything else is dropped inside a comment,
  // and the ';' that opens the comment is dropped too.
  assign store = push && ((in_data == NL) || (!strip_flag && (in_data != SEMI)));

  // Comment tracking: ';' opens a comment and newline closes it.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      strip_flag <= 1'b0;
    end else if (push) begin
      if (in_data == NL)
        strip_flag <= 1'b0;
      else if (in_data == SEMI)
        strip_flag <= 1'b1;
    end
  end
`else
  assign store = push;
`endif

  assign nl_in = store && (in_data == NL);

  // Next fill level and line count; a simultaneous push and pop cancel out.
  always_comb begin
    level_next = level;
    lc_next    = line_count;
    if (store && !pop)
      level_next = level + ONE_LVL;
    else if (!store && pop)
      level_next = level - ONE_LVL;
    if (nl_in && !nl_out)
      lc_next = line_count + ONE_LVL;
    else if (!nl_in && nl_out)
      lc_next = line_count - ONE_LVL;
  end

  // Byte storage. There is no reset, so this can map onto RAM.
  always_ff @(posedge clk) begin
    if (store)
      mem[wr_ptr] <= in_data;
  end

  // Pointers, occupancy and the sticky overflow flag.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      level      <= '0;
      line_count <= '0;
      overflow   <= 1'b0;
    end else begin
      if (store)
        wr_ptr <= wr_ptr + ONE_PTR;
      if (pop)
        rd_ptr <= rd_ptr + ONE_PTR;
      level      <= level_next;
      line_count <= lc_next;
      // The flag sets on the same edge the FIFO becomes full with no line stored.
      if ((level_next == FULL_LVL) && (lc_next == '0))
        overflow <= 1'b1;
    end
  end

  // Read FSM: pop into tx_data, pulse tx_start, then follow the UART busy cycle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      tx_start <= 1'b0;
      tx_data  <= 8'h00;
      hi_cnt   <= 2'd0;
    end else begin
      case (state)
        IDLE: begin
          if (pop) begin
            tx_data  <= head;
            tx_start <= 1'b1;
            state    <= START;
          end
        end
        START: begin
          tx_start <= 1'b0;
          hi_cnt   <= 2'd0;
          state    <= WAIT_HI;
        end
        WAIT_HI: begin
          // If busy never rises, give up after four cycles and count the byte as sent.
          if (tx_busy)
            state <= WAIT_LO;
          else if (hi_cnt == 2'd3)
            state <= IDLE;
          else
            hi_cnt <= hi_cnt + 2'd1;
        end
        WAIT_LO: begin
          if (!tx_busy)
            state <= IDLE;
        end
        default: begin
          state    <= IDLE;
          tx_start <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_gcode_tx_fifo.sv
// tb_gcode_tx_fifo: self-checking bench for gcode_tx_fifo (DEPTH=8).
// The reference model is a byte queue: a byte may leave only while the queue
// holds a newline or overflow is set. A small UART model answers tx_start with
// a busy pulse. Honours TX_FIFO_STRIP_COMMENT_EN when defined.
module tb_gcode_tx_fifo;

  localparam int DEPTH  = 8;
  localparam int ADDR_W = 3;

  logic              clk = 1'b0;
  logic              reset = 1'b0;
  logic              in_valid = 1'b0;
  logic [7:0]        in_data = 8'h00;
  logic              in_ready;
  logic              tx_busy = 1'b0;
  logic              tx_start;
  logic [7:0]        tx_data;
  logic [ADDR_W:0]   level;
  logic [ADDR_W:0]   line_count;
  logic              overflow;

  gcode_tx_fifo #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
    .clk        (clk),
    .reset      (reset),
    .in_valid   (in_valid),
    .in_data    (in_data),
    .in_ready   (in_ready),
    .tx_busy    (tx_busy),
    .tx_start   (tx_start),
    .tx_data    (tx_data),
    .level      (level),
    .line_count (line_count),
    .overflow   (overflow)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model state
  byte unsigned mq[$];
  byte unsigned sent_q[$];
  bit           m_ovf;
  bit           m_strip;
  byte unsigned last_tx;
  int           since_start;

  // UART model state
  int  uart_mode;      // 0: tx_busy driven by the test, 1: responds to tx_start
  bit  rand_uart;
  int  u_rise_fix;
  int  u_len_fix;
  bit  u_active;
  int  u_cnt_rise;
  int  u_cnt_len;

  typedef struct {
    bit         valid;
    logic [7:0] data;
    bit         rdy;
    int         lvl;
    int         lc;
  } vec_t;
  vec_t vt[10];

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t", name, act, act, exp, exp, $time);
    end
  endtask

  function automatic int count_nl();
    int c = 0;
    foreach (mq[i]) if (mq[i] == 8'h0A) c++;
    return c;
  endfunction

  function automatic void model_push(input byte unsigned d);
`ifdef TX_FIFO_STRIP_COMMENT_EN
    if (d == 8'h0A) begin
      m_strip = 1'b0;
      mq.push_back(d);
    end else if (!m_strip) begin
      if (d == 8'h3B) m_strip = 1'b1;
      else mq.push_back(d);
    end
`else
    mq.push_back(d);
`endif
  endfunction

  function automatic void reset_model();
    mq.delete();
    sent_q.delete();
    m_ovf       = 1'b0;
    m_strip     = 1'b0;
    last_tx     = 8'h00;
    since_start = 100;
    u_active    = 1'b0;
  endfunction

  // One clock: the inputs were already driven at the negedge. Update the model
  // and compare everything at the following negedge.
  task automatic cycle();
    bit acc;
    bit pre_busy;
    bit pre_allowed;
    byte unsigned acc_d;
    acc         = in_valid && in_ready;
    acc_d       = in_data;
    pre_busy    = tx_busy;
    pre_allowed = (count_nl() > 0) || m_ovf;
    @(posedge clk);
    @(negedge clk);
    since_start++;
    if (acc) model_push(acc_d);
    if (tx_start) begin
      check("pop_allowed", int'(pre_allowed), 1);
      check("pop_not_busy", int'(pre_busy), 0);
      check("start_gap_ge4", int'(since_start >= 4), 1);
      since_start = 0;
      check("queue_nonempty", int'(mq.size() > 0), 1);
      if (mq.size() > 0) begin
        check("tx_data", int'(tx_data), int'(mq[0]));
        void'(mq.pop_front());
      end
      sent_q.push_back(tx_data);
      last_tx = tx_data;
      if (uart_mode == 1) begin
        u_active = 1'b1;
        if (rand_uart) begin
          u_cnt_rise = ($urandom_range(0, 9) == 0) ? 6 : $urandom_range(0, 2);
          u_cnt_len  = $urandom_range(1, 12);
        end else begin
          u_cnt_rise = u_rise_fix;
          u_cnt_len  = u_len_fix;
        end
      end
    end else begin
      check("tx_data_hold", int'(tx_data), int'(last_tx));
    end
    if ((mq.size() == DEPTH) && (count_nl() == 0)) m_ovf = 1'b1;
    check("level", int'(level), mq.size());
    check("line_count", int'(line_count), count_nl());
    check("overflow", int'(overflow), int'(m_ovf));
    check("in_ready", int'(in_ready), int'(mq.size() != DEPTH));
    if (uart_mode == 1) begin
      if (!u_active) begin
        tx_busy = 1'b0;
      end else if (u_cnt_rise > 0) begin
        u_cnt_rise--;
        tx_busy = 1'b0;
      end else if (u_cnt_len > 0) begin
        u_cnt_len--;
        tx_busy = 1'b1;
      end else begin
        tx_busy  = 1'b0;
        u_active = 1'b0;
      end
    end
  endtask

  task automatic do_reset();
    reset    = 1'b0;
    in_valid = 1'b0;
    tx_busy  = 1'b0;
    #1;
    check("rst_tx_start", int'(tx_start), 0);
    check("rst_level", int'(level), 0);
    check("rst_line_count", int'(line_count), 0);
    check("rst_overflow", int'(overflow), 0);
    check("rst_tx_data", int'(tx_data), 0);
    reset_model();
    repeat (2) @(negedge clk);
    reset = 1'b1;
    #1;
    check("rst_in_ready", int'(in_ready), 1);
  endtask

  task automatic push_byte(input byte unsigned d);
    int k;
    bit a;
    in_valid = 1'b1;
    in_data  = d;
    a = 1'b0;
    for (k = 0; k < 500; k++) begin
      a = in_ready;
      cycle();
      if (a) break;
    end
    check("push_accepted", int'(a), 1);
    in_valid = 1'b0;
  endtask

  task automatic wait_sent(input int n, input int budget);
    int k;
    k = 0;
    while (sent_q.size() < n && k < budget) begin
      cycle();
      k++;
    end
    check("sent_count", sent_q.size(), n);
  endtask

  task automatic check_sent(input string name, input byte unsigned exp[$]);
    check({name, "_len"}, sent_q.size(), exp.size());
    foreach (exp[i]) begin
      if (i < sent_q.size()) check(name, int'(sent_q[i]), int'(exp[i]));
    end
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    byte unsigned exp_q[$];
    int base;
    int r;
    int phase;
    bit nl_rare;

    vt[0] = '{1'b1, 8'h47, 1'b1, 1, 0};
    vt[1] = '{1'b0, 8'h00, 1'b1, 1, 0};
    vt[2] = '{1'b1, 8'h31, 1'b1, 2, 0};
    vt[3] = '{1'b1, 8'h0A, 1'b1, 3, 1};
    vt[4] = '{1'b1, 8'h0A, 1'b1, 4, 2};
    vt[5] = '{1'b1, 8'h41, 1'b1, 5, 2};
    vt[6] = '{1'b1, 8'h42, 1'b1, 6, 2};
    vt[7] = '{1'b1, 8'h0A, 1'b1, 7, 3};
    vt[8] = '{1'b1, 8'h43, 1'b0, 8, 3};
    vt[9] = '{1'b1, 8'h44, 1'b0, 8, 3};

    uart_mode  = 0;
    rand_uart  = 1'b0;
    u_rise_fix = 1;
    u_len_fix  = 10;

    // Table: transmitter held busy, so nothing leaves and the occupancy is exact.
    do_reset();
    tx_busy = 1'b1;
    foreach (vt[i]) begin
      in_valid = vt[i].valid;
      in_data  = vt[i].data;
      cycle();
      $display("vec %0d: valid=%0d data=%02h -> level=%0d lines=%0d ready=%0d", i, vt[i].valid, vt[i].data, level, line_count, in_ready);
      check("vec_level", int'(level), vt[i].lvl);
      check("vec_line_count", int'(line_count), vt[i].lc);
      check("vec_in_ready", int'(in_ready), int'(vt[i].rdy));
      check("vec_overflow", int'(overflow), 0);
      check("vec_tx_start", int'(tx_start), 0);
    end
    in_valid  = 1'b0;
    tx_busy   = 1'b0;
    uart_mode = 1;
    wait_sent(7, 600);
    exp_q = '{8'h47, 8'h31, 8'h0A, 8'h0A, 8'h41, 8'h42, 8'h0A};
    check_sent("vec_drain", exp_q);
    repeat (30) cycle();
    check("vec_tail_level", int'(level), 1);

    // Test 1: "G1\n" goes out in order after the newline is stored.
    do_reset();
    push_byte(8'h47);
    push_byte(8'h31);
    check("t1_no_early_start", sent_q.size(), 0);
    push_byte(8'h0A);
    wait_sent(3, 200);
    exp_q = '{8'h47, 8'h31, 8'h0A};
    check_sent("t1_bytes", exp_q);
    repeat (20) cycle();
    check("t1_level", int'(level), 0);
    check("t1_line_count", int'(line_count), 0);
    $display("t1: sent %0d bytes", sent_q.size());

    // Test 2: an incomplete line is held back until its newline arrives.
    do_reset();
    push_byte(8'h47);
    push_byte(8'h32);
    repeat (100) cycle();
    check("t2_held", sent_q.size(), 0);
    check("t2_level", int'(level), 2);
    push_byte(8'h0A);
    wait_sent(3, 200);
    exp_q = '{8'h47, 8'h32, 8'h0A};
    check_sent("t2_bytes", exp_q);
    $display("t2: sent %0d bytes", sent_q.size());

    // Test 3: filling the FIFO with no newline sets overflow, which then drains it.
    do_reset();
    for (int i = 0; i < DEPTH; i++) push_byte(8'h41);
    check("t3_level_full", int'(level), DEPTH);
    check("t3_in_ready_full", int'(in_ready), 0);
    check("t3_overflow_set", int'(overflow), 1);
    wait_sent(DEPTH, 600);
    repeat (20) cycle();
    check("t3_in_ready_back", int'(in_ready), 1);
    check("t3_overflow_sticky", int'(overflow), 1);
    check("t3_level_empty", int'(level), 0);
    $display("t3: drained %0d bytes", sent_q.size());

    // Test 4: a newline pushed on the same edge as a newline pop.
    do_reset();
    uart_mode = 0;
    tx_busy   = 1'b1;
    push_byte(8'h0A);
    check("t4_pre_level", int'(level), 1);
    in_valid = 1'b1;
    in_data  = 8'h0A;
    tx_busy  = 1'b0;
    cycle();
    in_valid = 1'b0;
    check("t4_popped", int'(tx_start), 1);
    check("t4_level", int'(level), 1);
    check("t4_line_count", int'(line_count), 1);
    uart_mode = 1;
    wait_sent(2, 200);
    $display("t4: sent %0d bytes", sent_q.size());

    // Test 5: an asynchronous reset in WAIT_LO abandons the transfer.
    do_reset();
    uart_mode = 0;
    tx_busy   = 1'b1;
    push_byte(8'h0A);
    push_byte(8'h41);
    push_byte(8'h42);
    push_byte(8'h43);
    push_byte(8'h44);
    push_byte(8'h0A);
    uart_mode  = 1;
    u_rise_fix = 0;
    u_len_fix  = 30;
    tx_busy    = 1'b0;
    wait_sent(1, 50);
    repeat (3) cycle();
    check("t5_pre_level", int'(level), 5);
    #2;
    reset = 1'b0;
    #1;
    check("t5_tx_start", int'(tx_start), 0);
    check("t5_level", int'(level), 0);
    check("t5_line_count", int'(line_count), 0);
    check("t5_overflow", int'(overflow), 0);
    reset_model();
    tx_busy = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    repeat (30) cycle();
    check("t5_no_resume", sent_q.size(), 0);
    u_rise_fix = 1;
    u_len_fix  = 10;
    $display("t5: reset mid-transfer, %0d bytes after release", sent_q.size());

    // Test 6: comment stripping (or verbatim transmission without the macro).
    do_reset();
    push_byte(8'h47);
    push_byte(8'h31);
    push_byte(8'h3B);
    push_byte(8'h78);
    push_byte(8'h79);
    push_byte(8'h0A);
`ifdef TX_FIFO_STRIP_COMMENT_EN
    exp_q = '{8'h47, 8'h31, 8'h0A};
`else
    exp_q = '{8'h47, 8'h31, 8'h3B, 8'h78, 8'h79, 8'h0A};
`endif
    wait_sent(exp_q.size(), 400);
    repeat (30) cycle();
    check_sent("t6_bytes", exp_q);
    $display("t6: sent %0d bytes", sent_q.size());

    // Random traffic against the queue model, with long newline-free stretches.
    do_reset();
    rand_uart = 1'b1;
    for (int i = 0; i < 3000; i++) begin
      phase   = (i / 500) % 2;
      nl_rare = (phase == 1);
      in_valid = ($urandom_range(0, 3) != 0);
      r = nl_rare ? $urandom_range(0, 39) : $urandom_range(0, 9);
      if (r <= 1 && !(nl_rare && r == 1))
        in_data = 8'h0A;
      else if (r == 2)
        in_data = 8'h3B;
      else
        in_data = 8'($urandom_range(8'h20, 8'h7E));
      cycle();
    end
    in_valid = 1'b0;
    base = sent_q.size();
    repeat (400) cycle();
    $display("random: sent %0d bytes, %0d left", base, mq.size());

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
